// File: rtl/sram_pkg.sv
// Shared constants and helpers for the pipelined SRAM block.
package sram_pkg;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 4;

   function automatic int unsigned be_width(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response buffer; pointers wrap modulo DEPTH, which need not be a power of two.
module sram_rsp_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= push_data;
   end

   assign empty = (count == '0);
   assign head  = store[rd_ptr];

endmodule

// File: rtl/sram_pipe.sv
// Single-port SRAM with byte-enable writes, fixed-latency reads and a
// credit-controlled response FIFO that can never overflow.
`ifndef RAM_ADDR_BITS
`define RAM_ADDR_BITS 10
`endif

module sram_pipe
   import sram_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = `RAM_ADDR_BITS,
   parameter int unsigned RD_LAT    = 2,
   parameter bit          ZERO_MASK = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_we,
   input  logic [ADDR_W-1:0]           req_addr,
   input  logic [be_width(DATA_W)-1:0] req_byteen,
   input  logic [DATA_W-1:0]           req_data,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [DATA_W-1:0]           rsp_data
);

   localparam int unsigned BE_W  = be_width(DATA_W);
   localparam int unsigned LAT   = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                   (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
   localparam int unsigned DEPTH = LAT + 1;
   localparam int unsigned CRW   = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [CRW-1:0]    credits;
   logic              rd_acc;
   logic              wr_acc;
   logic              pop;
   logic              push;
   logic              empty;
   logic [DATA_W-1:0] s0_data;
   logic [DATA_W-1:0] push_data;

   assign req_ready = !rst && (credits != '0);
   assign rd_acc    = req_valid && req_ready && !req_we;
   assign wr_acc    = req_valid && req_ready && req_we;
   assign rsp_valid = !rst && !empty;
   assign pop       = rsp_valid && rsp_ready;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int unsigned i = 0; i < BE_W; i++) begin
            if (req_byteen[i]) mem[req_addr][8*i +: 8] <= req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      s0_data = mem[req_addr];
      if (ZERO_MASK) begin
         for (int unsigned i = 0; i < BE_W; i++) begin
            if (!req_byteen[i]) s0_data[8*i +: 8] = 8'h00;
         end
      end
   end

   // With LAT==1 the array read feeds the FIFO directly so the response
   // is visible the cycle after acceptance; longer latencies add stages.
   generate
      if (LAT == 1) begin : g_direct
         assign push      = rd_acc;
         assign push_data = s0_data;
      end else begin : g_pipe
         logic [LAT-2:0]    pv;
         logic [DATA_W-1:0] pd [LAT-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               pv <= '0;
            end else begin
               pv[0] <= rd_acc;
               for (int unsigned i = 1; i < LAT - 1; i++) pv[i] <= pv[i-1];
            end
         end

         always_ff @(posedge clk) begin
            if (rd_acc) pd[0] <= s0_data;
            for (int unsigned i = 1; i < LAT - 1; i++) pd[i] <= pd[i-1];
         end

         assign push      = pv[LAT-2];
         assign push_data = pd[LAT-2];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= CRW'(DEPTH);
      end else begin
         case ({rd_acc, pop})
            2'b10:   credits <= credits - 1'b1;
            2'b01:   credits <= credits + 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   sram_rsp_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .empty     (empty),
      .head      (rsp_data)
   );

endmodule

// File: doc/sram_pipe.md
SRAM_PIPE -- requirements
Module: sram_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default `RAM_ADDR_BITS, word address width; depth 2**ADDR_W words.
REQ-003 SHALL have parameter RD_LAT, default 2, read latency in cycles from request acceptance to response eligibility, legal range 1..4.
REQ-004 SHALL have parameter ZERO_MASK, default 1; 1 = bytes with byteen low read as 8'h00, 0 = full word returned.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-009 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  ADDR_W  word address.
REQ-011 SHALL have port req_byteen  input  DATA_W/8  per-byte enable, bit i covers data[8i+7:8i].
REQ-012 SHALL have port req_data  input  DATA_W  write data.
REQ-013 SHALL have port rsp_valid  output  1  read data available.
REQ-014 SHALL have port rsp_ready  input  1  consumer accepts rsp_data when high with rsp_valid.
REQ-015 SHALL have port rsp_data  output  DATA_W  read data, in request order.

Function
REQ-016 Request handshake SHALL occur on a cycle with req_valid && req_ready; req_ready SHALL not depend combinationally on req_valid, req_we or rsp_ready.
REQ-017 Accepted write SHALL update only enabled bytes at req_addr at that clock edge; no response generated.
REQ-018 Accepted read SHALL latch req_byteen and sample memory so its data enters the response FIFO exactly RD_LAT cycles after acceptance.
REQ-019 Read accepted the cycle after a write to the same address SHALL return the new data (write visible next cycle).
REQ-020 Response FIFO depth SHALL be RD_LAT+1; rsp_valid = FIFO not empty; rsp_data = FIFO head, stable while rsp_valid && !rsp_ready.
REQ-021 Credit counter SHALL start at RD_LAT+1, decrement on read acceptance, increment on response handshake, unchanged when both occur in one cycle.
REQ-022 req_ready SHALL be high iff credits != 0 (writes also blocked at zero credits), guaranteeing no FIFO overflow.
REQ-023 With rsp_ready held high, back-to-back reads SHALL sustain one request per cycle indefinitely.
REQ-024 FIFO full and pipeline delivering SHALL be impossible by construction; verification SHALL assert it never occurs.
REQ-025 Read pointer and write pointer of the FIFO SHALL wrap modulo RD_LAT+1 without loss.
REQ-026 ZERO_MASK=1: response byte i SHALL be 8'h00 when the latched byteen[i] was 0.

Reset
REQ-027 While rst high: req_ready=0, rsp_valid=0, credits=RD_LAT+1, FIFO empty, pipeline valid bits cleared.
REQ-028 Reset mid-operation SHALL discard all in-flight and buffered reads; no stale response after reset release.
REQ-029 Memory array SHALL not be reset; rsp_data value while rsp_valid=0 is don't-care.
REQ-030 req_ready SHALL rise on the first cycle after rst deasserts.

Structure
REQ-031 Shared package sram_pkg SHALL hold RD_LAT min/max constants and the byte-enable-width function (DATA_W/8).
REQ-032 Response buffer SHALL be one sub-module sram_rsp_fifo (parametrised width, depth), instantiated once.
REQ-033 Memory array SHALL be an inferable single-port array with per-byte write, no vendor primitives.

Verification
REQ-034 Write addr 5 data 32'hDEADBEEF byteen 4'hF, then read addr 5 byteen 4'h3 -> rsp_data 32'h0000BEEF exactly RD_LAT cycles after read acceptance (ZERO_MASK=1).
REQ-035 Write addr 5 byteen 4'h4 data 32'h00AA0000 over 32'hDEADBEEF, next-cycle read byteen 4'hF -> 32'hDEAABEEF.
REQ-036 rsp_ready=0, issue reads until stall -> exactly RD_LAT+1 accepted, req_ready=0; raise rsp_ready -> responses in order, req_ready returns the next cycle.
REQ-037 rsp_ready=1, 16 consecutive reads addr 0..15 -> req_ready never drops, 16 in-order responses, one per cycle.
REQ-038 Assert rst with 2 reads in flight and 1 buffered -> rsp_valid=0 during and after reset, credits=RD_LAT+1, no response from the discarded reads.
REQ-039 Random traffic with random rsp_ready against a reference model, RD_LAT 1 and 4 -> zero mismatches, FIFO overflow assertion never fires.
